// File: rtl/stacker_ctrl_p.sv
// Stacker game controller: a lit block bounces across a row; a button edge
// locks the overlap with the row below, then play climbs until win or lose.
module stacker_ctrl_p #(
    parameter int WIDTH       = 8,
    parameter int ROWS        = 8,
    parameter int INIT_LEN    = 3,
    parameter int PERIOD_INIT = 4,
    parameter int PERIOD_MIN  = 1,
    parameter int PERIOD_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      step_tick,
    input  logic                      btn,
    output logic [WIDTH-1:0]          val,
    output logic [$clog2(ROWS)-1:0]   row_index,
    output logic                      write_strobe,
    output logic                      clr_array,
    output logic                      win,
    output logic                      lose,
    output logic [$clog2(ROWS+1)-1:0] score,
    output logic [2:0]                dbg_state
);

    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(ROWS + 1);
    localparam int PW = $clog2(PERIOD_INIT + 1);

    localparam logic [WIDTH-1:0] INIT_PAT  = ~({WIDTH{1'b1}} >> INIT_LEN);
    localparam logic [RW-1:0]    LAST_ROW  = RW'(ROWS - 1);
    localparam logic [SW-1:0]    SCORE_MAX = SW'(ROWS);
    localparam logic [PW-1:0]    P_INIT    = PW'(PERIOD_INIT);
    localparam logic [PW-1:0]    P_MIN     = PW'(PERIOD_MIN);
    localparam logic [PW-1:0]    P_STEP    = PW'(PERIOD_STEP);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_TRACE = 3'd1,
        S_LOCK  = 3'd2,
        S_NEXT  = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic             btn_q;
    logic             btn_edge;
    logic [WIDTH-1:0] curr, prev;
    logic [WIDTH-1:0] trim;
    logic [WIDTH-1:0] moved;
    logic             dir_right, dir_nx;
    logic             stuck;
    logic [PW-1:0]    period, period_dec;
    logic [PW-1:0]    tick_cnt;
    logic             move_due;

    assign btn_edge = btn & ~btn_q;
    assign trim     = curr & prev;
    assign stuck    = curr[0] & curr[WIDTH-1];
    assign move_due = step_tick && (tick_cnt == period - PW'(1));

    // Bounce: reverse at either wall, so the block never shifts bits out.
    always_comb begin
        moved  = curr;
        dir_nx = dir_right;
        if (stuck) begin
            moved = curr;
        end else if (dir_right && curr[0]) begin
            dir_nx = 1'b0;
            moved  = curr << 1;
        end else if (!dir_right && curr[WIDTH-1]) begin
            dir_nx = 1'b1;
            moved  = curr >> 1;
        end else if (dir_right) begin
            moved = curr >> 1;
        end else begin
            moved = curr << 1;
        end
    end

    always_comb begin
        period_dec = P_MIN;
        if (int'(period) >= PERIOD_MIN + PERIOD_STEP) begin
            period_dec = period - P_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = S_INIT;
        case (state)
            S_INIT:  state_nx = S_TRACE;
            S_TRACE: state_nx = btn_edge ? S_LOCK : S_TRACE;
            S_LOCK: begin
                if (trim == '0) begin
                    state_nx = S_LOSE;
                end else if (row_index == LAST_ROW) begin
                    state_nx = S_WIN;
                end else begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT:  state_nx = S_TRACE;
            S_WIN:   state_nx = btn_edge ? S_INIT : S_WIN;
            S_LOSE:  state_nx = btn_edge ? S_INIT : S_LOSE;
            default: state_nx = S_INIT;
        endcase
    end

    always_comb begin
        clr_array = (state == S_INIT);
        win       = (state == S_WIN);
        lose      = (state == S_LOSE);
        dbg_state = state;
    end

    // write_strobe is a one-cycle qualifier with no back-pressure: val and
    // row_index are meaningful only in cycles where it is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q        <= 1'b0;
            curr         <= '0;
            prev         <= '0;
            dir_right    <= 1'b1;
            period       <= P_INIT;
            tick_cnt     <= '0;
            val          <= '0;
            row_index    <= '0;
            write_strobe <= 1'b0;
            score        <= '0;
        end else begin
            btn_q        <= btn;
            write_strobe <= 1'b0;
            case (state)
                S_INIT: begin
                    curr         <= INIT_PAT;
                    prev         <= '1;
                    dir_right    <= 1'b1;
                    period       <= P_INIT;
                    tick_cnt     <= '0;
                    row_index    <= '0;
                    score        <= '0;
                    val          <= INIT_PAT;
                    write_strobe <= 1'b1;
                end
                S_TRACE: begin
                    // The lock strobe is issued on entry so it lands in the LOCK cycle.
                    if (btn_edge) begin
                        val          <= trim;
                        write_strobe <= 1'b1;
                    end else if (move_due) begin
                        tick_cnt <= '0;
                        if (!stuck) begin
                            curr         <= moved;
                            dir_right    <= dir_nx;
                            val          <= moved;
                            write_strobe <= 1'b1;
                        end
                    end else if (step_tick) begin
                        tick_cnt <= tick_cnt + PW'(1);
                    end
                end
                S_LOCK: begin
                    if (trim != '0) begin
                        if (score != SCORE_MAX) begin
                            score <= score + SW'(1);
                        end
                        if (row_index != LAST_ROW) begin
                            row_index    <= row_index + RW'(1);
                            prev         <= trim;
                            curr         <= trim;
                            dir_right    <= 1'b1;
                            tick_cnt     <= '0;
                            period       <= period_dec;
                            val          <= trim;
                            write_strobe <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
